// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - FETCH/READ_IR/DECODE/EXEC bus control sequencer; SEQ_WAIT_EN adds memory wait states
module bus_sequencer #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic [1:0]      alu_op
);

    typedef enum logic [1:0] {FETCH, READ_IR, DECODE, EXEC} state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);

`ifdef SEQ_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    // The opcode must leave at least one operand/address bit in the bus word.
    if (WORD_W <= OP_W) begin : g_width_check
        $error("bus_sequencer: WORD_W must exceed OP_W");
    end

    state_t state;
    state_t state_nxt;
    logic   mem_access;

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        PC_bus     = 1'b0;
        load_PC    = 1'b0;
        INC_PC     = 1'b0;
        load_IR    = 1'b0;
        Addr_bus   = 1'b0;
        load_MAR   = 1'b0;
        MDR_bus    = 1'b0;
        load_MDR   = 1'b0;
        CS         = 1'b0;
        R_NW       = 1'b1;
        ACC_bus    = 1'b0;
        load_ACC   = 1'b0;
        alu_op     = 2'b00;
        mem_access = 1'b0;
        state_nxt  = FETCH;

        case (state)
            FETCH: begin
                PC_bus    = 1'b1;
                load_MAR  = 1'b1;
                INC_PC    = 1'b1;
                state_nxt = READ_IR;
            end
            READ_IR: begin
                CS         = 1'b1;
                MDR_bus    = 1'b1;
                load_IR    = 1'b1;
                mem_access = 1'b1;
                state_nxt  = DECODE;
            end
            DECODE: begin
                Addr_bus  = 1'b1;
                load_MAR  = 1'b1;
                state_nxt = EXEC;
            end
            default: begin
                state_nxt = FETCH;
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        CS         = 1'b1;
                        MDR_bus    = 1'b1;
                        load_ACC   = 1'b1;
                        mem_access = 1'b1;
                        alu_op     = (op == OP_ADD) ? 2'b01 :
                                     (op == OP_SUB) ? 2'b10 : 2'b00;
                    end
                    OP_STORE: begin
                        ACC_bus    = 1'b1;
                        load_MDR   = 1'b1;
                        CS         = 1'b1;
                        R_NW       = 1'b0;
                        mem_access = 1'b1;
                    end
                    OP_BNE: begin
                        // Indirect branch: the fetched word is the target address.
                        if (!z_flag) begin
                            CS         = 1'b1;
                            MDR_bus    = 1'b1;
                            load_PC    = 1'b1;
                            mem_access = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        if (WAIT_EN && mem_access && !mem_ready) begin
            state_nxt = state;
        end

        // Hold every strobe quiet while reset is asserted, whatever the state.
        if (!n_reset) begin
            PC_bus   = 1'b0;
            load_PC  = 1'b0;
            INC_PC   = 1'b0;
            load_IR  = 1'b0;
            Addr_bus = 1'b0;
            load_MAR = 1'b0;
            MDR_bus  = 1'b0;
            load_MDR = 1'b0;
            CS       = 1'b0;
            R_NW     = 1'b1;
            ACC_bus  = 1'b0;
            load_ACC = 1'b0;
            alu_op   = 2'b00;
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - scoreboard bench for bus_sequencer with instruction-level reference model
module tb_bus_sequencer;

    logic       clock = 1'b0;
    logic       n_reset;
    logic [2:0] op;
    logic       z_flag;
    logic       mem_ready;
    logic       PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
    logic       MDR_bus, load_MDR, CS, R_NW, ACC_bus, load_ACC;
    logic [1:0] alu_op;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int phase  = 0;

    logic [13:0] exp_q[$];

    bus_sequencer #(.WORD_W(8), .OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready),
        .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC), .load_IR(load_IR),
        .Addr_bus(Addr_bus), .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
        .CS(CS), .R_NW(R_NW), .ACC_bus(ACC_bus), .load_ACC(load_ACC), .alu_op(alu_op)
    );

    always #5 clock = ~clock;

    // Expected output word for one cycle of an instruction, built from the per-step strobe lists.
    function automatic logic [13:0] expect_vec(input int ph, input logic [2:0] o, input bit z);
        bit pc_b = 0, ld_pc = 0, inc = 0, ld_ir = 0, ad_b = 0, ld_mar = 0, mdr_b = 0;
        bit ld_mdr = 0, cs = 0, rnw = 1, acc_b = 0, ld_acc = 0;
        logic [1:0] alu = 2'b00;
        if (ph == 0) begin pc_b = 1; ld_mar = 1; inc = 1; end
        else if (ph == 1) begin cs = 1; mdr_b = 1; ld_ir = 1; end
        else if (ph == 2) begin ad_b = 1; ld_mar = 1; end
        else if (o == 3'd0) begin cs = 1; mdr_b = 1; ld_acc = 1; alu = 2'b00; end
        else if (o == 3'd1) begin acc_b = 1; ld_mdr = 1; cs = 1; rnw = 0; end
        else if (o == 3'd2) begin cs = 1; mdr_b = 1; ld_acc = 1; alu = 2'b01; end
        else if (o == 3'd3) begin cs = 1; mdr_b = 1; ld_acc = 1; alu = 2'b10; end
        else if (o == 3'd4 && !z) begin cs = 1; mdr_b = 1; ld_pc = 1; end
        return {pc_b, ld_pc, inc, ld_ir, ad_b, ld_mar, mdr_b, ld_mdr, cs, rnw, acc_b, ld_acc, alu};
    endfunction

    function automatic bit touches_memory(input int ph, input logic [2:0] o, input bit z);
        return (ph == 1) || (ph == 3 && (o <= 3'd3 || (o == 3'd4 && !z)));
    endfunction

    task automatic cycle(input bit rn, input logic [2:0] o, input bit z, input bit mr);
        bit stall;
        n_reset   = rn;
        op        = o;
        z_flag    = z;
        mem_ready = mr;
        if (!rn) begin
            exp_q.push_back(14'b00000000010000);
            phase = 0;
        end else begin
            exp_q.push_back(expect_vec(phase, o, z));
            stall = 1'b0;
`ifdef SEQ_WAIT_EN
            stall = touches_memory(phase, o, z) && !mr;
`endif
            if (!stall) phase = (phase + 1) % 4;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic instr(input logic [2:0] o, input bit z);
        for (int i = 0; i < 4; i++) cycle(1'b1, o, z, 1'b1);
    endtask

    always @(negedge clock) begin
        logic [13:0] got;
        logic [13:0] want;
        got = {PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, MDR_bus, load_MDR,
               CS, R_NW, ACC_bus, load_ACC, alu_op};
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %b expected %b", cyc, got, want);
            end
            checks++;
            if ($countones({PC_bus, Addr_bus, MDR_bus, ACC_bus}) > 1) begin
                errors++;
                $display("FAIL bus_drivers cycle %0d: got %0d drivers expected at most 1",
                         cyc, $countones({PC_bus, Addr_bus, MDR_bus, ACC_bus}));
            end
        end
        cyc++;
    end

    initial begin
        n_reset   = 1'b0;
        op        = 3'd0;
        z_flag    = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        cycle(1'b0, 3'd5, 1'b1, 1'b1);
        cycle(1'b0, 3'd1, 1'b0, 1'b0);

        instr(3'd0, 1'b0);
        instr(3'd1, 1'b0);
        instr(3'd4, 1'b0);
        instr(3'd4, 1'b1);
        instr(3'd3, 1'b0);
        instr(3'd2, 1'b1);
        instr(3'd7, 1'b0);
        instr(3'd5, 1'b1);

        // Reset during EXEC of a STORE, then a clean LOAD.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd1, 1'b0, 1'b1);
        cycle(1'b0, 3'd1, 1'b0, 1'b1);
        instr(3'd0, 1'b0);

        // Opcode and flag wiggling outside EXEC must not matter.
        cycle(1'b1, 3'd1, 1'b1, 1'b1);
        cycle(1'b1, 3'd4, 1'b0, 1'b1);
        cycle(1'b1, 3'd7, 1'b1, 1'b1);
        cycle(1'b1, 3'd3, 1'b0, 1'b1);

        // READ_IR wait states; ignored unless the wait feature is built in.
        cycle(1'b1, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd0, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 24) != 0, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        end

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
